// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry skid buffer and
// redirect handling for an in-order pipeline.
//
// Ports
//   clk         sole clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   imem_addr   fetch address (the registered PCF)
//   imem_req    fetch request, held with a stable imem_addr until imem_ready
//   imem_ready  imem_rdata valid this cycle, completes the request
//   imem_rdata  returned instruction word
//   PCSrc       redirect (taken branch / jal) from execute
//   PCTarget    redirect address
//   StallD      decode cannot accept a new instruction
//   InstrD      IF/ID instruction (NOP 0x00000013 when a bubble)
//   PCD         PC of InstrD
//   PCPlus4D    PCD + 4
//   ValidD      InstrD is a real instruction, not a bubble
//
// Optional feature: define IF_STAGE_PERF_CNT_EN to add
//   fetch_cnt   instructions loaded into IF/ID with ValidD=1
//   bubble_cnt  cycles in which IF/ID was loaded with a bubble
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        StallD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // FETCH    : request outstanding, decode side free to receive
    // BUFFERED : a fetched word waits in the skid buffer, no request
    // DROP     : request outstanding whose data must be thrown away
    typedef enum logic [1:0] {
        FETCH    = 2'b00,
        BUFFERED = 2'b01,
        DROP     = 2'b10
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pcf_reg, pcf_next;
    logic [31:0] redir_reg, redir_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pcd_reg, pcd_next;
    logic [31:0] pcplus4d_reg, pcplus4d_next;
    logic        validd_reg, validd_next;

    logic        load_word;
    logic        load_bubble;
    logic [31:0] word_sel;
    logic [31:0] word_pc;

    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        redir_next      = redir_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        load_word       = 1'b0;
        load_bubble     = 1'b0;
        word_sel        = imem_rdata;
        word_pc         = pcf_reg;

        if (PCSrc) begin
            // Flush wins over StallD; the skid contents are wrong-path.
            load_bubble     = 1'b1;
            skid_instr_next = '0;
            skid_pc_next    = '0;
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        pcf_next = PCTarget;
                    end else begin
                        // Request cannot be withdrawn: remember the target
                        // and let the stale response drain first.
                        redir_next = PCTarget;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        pcf_next   = PCTarget;
                        state_next = FETCH;
                    end else begin
                        redir_next = PCTarget;
                    end
                end
                default: begin
                    pcf_next   = PCTarget;
                    state_next = FETCH;
                end
            endcase
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        pcf_next = pcf_reg + 32'd4;
                        if (!StallD) begin
                            load_word = 1'b1;
                        end else begin
                            skid_instr_next = imem_rdata;
                            skid_pc_next    = pcf_reg;
                            state_next      = BUFFERED;
                        end
                    end else if (!StallD) begin
                        load_bubble = 1'b1;
                    end
                end
                BUFFERED: begin
                    if (!StallD) begin
                        load_word  = 1'b1;
                        word_sel   = skid_instr_reg;
                        word_pc    = skid_pc_reg;
                        state_next = FETCH;
                    end
                end
                DROP: begin
                    if (!StallD) begin
                        load_bubble = 1'b1;
                    end
                    if (imem_ready) begin
                        pcf_next   = redir_reg;
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end

        instr_d_next  = instr_d_reg;
        pcd_next      = pcd_reg;
        pcplus4d_next = pcplus4d_reg;
        validd_next   = validd_reg;
        if (load_word) begin
            instr_d_next  = word_sel;
            pcd_next      = word_pc;
            pcplus4d_next = word_pc + 32'd4;
            validd_next   = 1'b1;
        end else if (load_bubble) begin
            instr_d_next = NOP;
            validd_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FETCH;
            pcf_reg        <= RESET_PC;
            redir_reg      <= '0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            instr_d_reg    <= NOP;
            pcd_reg        <= '0;
            pcplus4d_reg   <= '0;
            validd_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pcf_reg        <= pcf_next;
            redir_reg      <= redir_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            instr_d_reg    <= instr_d_next;
            pcd_reg        <= pcd_next;
            pcplus4d_reg   <= pcplus4d_next;
            validd_reg     <= validd_next;
        end
    end

    // Address comes straight from a register: no path from the pipeline
    // control inputs or the memory data to imem_addr.
    assign imem_addr = pcf_reg;
    assign imem_req  = !reset && (state_reg != BUFFERED);
    assign InstrD    = instr_d_reg;
    assign PCD       = pcd_reg;
    assign PCPlus4D  = pcplus4d_reg;
    assign ValidD    = validd_reg;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (load_word) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (load_bubble) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A transaction-level model (PC, pending redirect, held word) predicts the
// outputs every cycle; directed literal checks pin the scenarios. A second
// instance with RESET_PC=0xFFFFFFFC covers PC wrap-around.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_ready;
    logic        PCSrc;
    logic        StallD;
    logic [31:0] PCTarget;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    logic        reset2;
    logic        ready2;
    logic        src2;
    logic        stall2;
    logic [31:0] tgt2;
    logic [31:0] rdata2;
    logic [31:0] addr2;
    logic        req2;
    logic [31:0] instr2;
    logic [31:0] pcd2;
    logic [31:0] pc4_2;
    logic        valid2;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] fetch_cnt2;
    logic [31:0] bubble_cnt2;
`endif

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .StallD     (StallD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk        (clk),
        .reset      (reset2),
        .imem_addr  (addr2),
        .imem_req   (req2),
        .imem_ready (ready2),
        .imem_rdata (rdata2),
        .PCSrc      (src2),
        .PCTarget   (tgt2),
        .StallD     (stall2),
        .InstrD     (instr2),
        .PCD        (pcd2),
        .PCPlus4D   (pc4_2),
        .ValidD     (valid2)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt2),
        .bubble_cnt (bubble_cnt2)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_raddr, m_hword, m_hpc;
    logic        m_pend, m_held;
    logic        m_valid;
    logic [31:0] m_instr, m_pcd, m_pc4;
    logic [31:0] m_fcnt, m_bcnt;

    task automatic m_present(input logic [31:0] w, input logic [31:0] pc);
        m_valid = 1'b1;
        m_instr = w;
        m_pcd   = pc;
        m_pc4   = pc + 32'd4;
        m_fcnt  = m_fcnt + 32'd1;
    endtask

    task automatic m_bubble();
        m_valid = 1'b0;
        m_instr = NOP;
        m_bcnt  = m_bcnt + 32'd1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_pend = 1'b0; m_raddr = 32'h0; m_held = 1'b0;
            m_hword = 32'h0; m_hpc = 32'h0;
            m_valid = 1'b0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
            m_fcnt = 32'h0; m_bcnt = 32'h0;
        end else if (PCSrc) begin
            m_bubble();
            if (m_held) begin
                m_pc = PCTarget;           // no request outstanding
            end else if (imem_ready) begin
                m_pc = PCTarget;           // outstanding request finished now
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;             // wait for the stale response
                m_raddr = PCTarget;
            end
            m_held = 1'b0;
        end else if (m_held) begin
            if (!StallD) begin
                m_present(m_hword, m_hpc);
                m_held = 1'b0;
            end
        end else if (imem_ready) begin
            if (m_pend) begin
                m_pc = m_raddr;
                m_pend = 1'b0;
                if (!StallD) m_bubble();
            end else if (!StallD) begin
                m_present(mem_word(m_pc), m_pc);
                m_pc = m_pc + 32'd4;
            end else begin
                m_held = 1'b1;
                m_hword = mem_word(m_pc);
                m_hpc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end else if (!StallD) begin
            m_bubble();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("imem_req", 32'(imem_req), 32'(!reset && !m_held));
        check("imem_addr", imem_addr, m_pc);
        check("ValidD", 32'(ValidD), 32'(m_valid));
        check("InstrD", InstrD, m_instr);
        if (m_valid) begin
            check("PCD", PCD, m_pcd);
            check("PCPlus4D", PCPlus4D, m_pc4);
        end
`ifdef IF_STAGE_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, m_fcnt);
        check("bubble_cnt", bubble_cnt, m_bcnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step(input string lbl, input logic r, input logic rdy, input logic src,
                        input logic [31:0] tgt, input logic st);
        reset = r; imem_ready = rdy; PCSrc = src; PCTarget = tgt; StallD = st;
        @(negedge clk);
        #1;
        $display("[TB] %s: addr=%h req=%b ValidD=%b PCD=%h InstrD=%h",
                 lbl, imem_addr, imem_req, ValidD, PCD, InstrD);
    endtask

    initial begin
        reset2 = 1'b1; ready2 = 1'b1; src2 = 1'b0; stall2 = 1'b0; tgt2 = 32'h0;

        step("reset", 1, 1, 0, 32'h0, 0);
        step("reset", 1, 1, 0, 32'h0, 0);
        check("rst_valid", 32'(ValidD), 32'h0);
        check("rst_instr", InstrD, 32'h0000_0013);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pc4", PCPlus4D, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);

        // First request right after reset release.
        reset = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);

        step("zw0", 0, 1, 0, 32'h0, 0);
        check("zw_pcd0", PCD, 32'h0);
        check("zw_valid", 32'(ValidD), 32'h1);
        check("zw_instr0", InstrD, 32'h0000_FFFF);
        step("zw4", 0, 1, 0, 32'h0, 0);
        check("zw_pcd4", PCD, 32'h4);

        // Stall while fetching PC 8: word goes to the skid buffer.
        step("stall1", 0, 1, 0, 32'h0, 1);
        check("stall_req", 32'(imem_req), 32'h0);
        check("stall_hold", PCD, 32'h4);
        step("stall2", 0, 1, 0, 32'h0, 1);
        step("stall3", 0, 1, 0, 32'h0, 1);
        check("stall3_hold", PCD, 32'h4);
        step("release", 0, 1, 0, 32'h0, 0);
        check("rel_pcd", PCD, 32'h8);
        check("rel_instr", InstrD, 32'h0008_FFF7);
        step("after_rel", 0, 1, 0, 32'h0, 0);
        check("after_rel_pcd", PCD, 32'hC);

        // Redirect with a request outstanding.
        step("redir_wait", 0, 0, 1, 32'h100, 0);
        check("drop_instr", InstrD, NOP);
        check("drop_addr", imem_addr, 32'h10);
        step("drop", 0, 0, 0, 32'h0, 0);
        check("drop_addr2", imem_addr, 32'h10);
        step("drop_ready", 0, 1, 0, 32'h0, 0);
        check("drop_next", imem_addr, 32'h100);
        check("drop_valid", 32'(ValidD), 32'h0);
        step("fetch100", 0, 1, 0, 32'h0, 0);
        check("pcd100", PCD, 32'h100);

        // Flush while buffered and stalled.
        step("stall_buf", 0, 1, 0, 32'h0, 1);
        step("flush_buf", 0, 1, 1, 32'h200, 1);
        check("flush_valid", 32'(ValidD), 32'h0);
        check("flush_instr", InstrD, NOP);
        check("flush_addr", imem_addr, 32'h200);
        step("fetch200", 0, 1, 0, 32'h0, 0);
        check("pcd200", PCD, 32'h200);

        // Repeated redirect while draining: latest target wins.
        step("redir300", 0, 0, 1, 32'h300, 0);
        step("redir400", 0, 0, 1, 32'h400, 0);
        step("drop_ready", 0, 1, 0, 32'h0, 0);
        check("latest_wins", imem_addr, 32'h400);
        step("fetch400", 0, 1, 0, 32'h0, 0);
        step("wait_stall", 0, 0, 0, 32'h0, 1);
        check("wait_stall_hold", PCD, 32'h400);
        step("wait", 0, 0, 0, 32'h0, 0);
        check("wait_bubble", 32'(ValidD), 32'h0);

        // Reset in the middle of a drain, with imem_ready high.
        step("redir500", 0, 0, 1, 32'h500, 0);
        step("reset_mid", 1, 1, 0, 32'h0, 0);
        check("rst_mid_addr", imem_addr, 32'h0);
        step("reset_rel", 0, 0, 0, 32'h0, 0);
        check("rst_rel_addr", imem_addr, 32'h0);

`ifdef IF_STAGE_PERF_CNT_EN
        step("perf_rst", 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) step("perf_zw", 0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) step("perf_wait", 0, 0, 0, 32'h0, 0);
        check("perf_fetch", fetch_cnt, 32'd10);
        check("perf_bubble", bubble_cnt, 32'd2);
`endif

        // PC wrap-around on the second instance.
        reset2 = 1'b0;
        #1;
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        check("wrap_req", 32'(req2), 32'h1);
        @(negedge clk);
        #1;
        $display("[TB] wrap0: addr=%h ValidD=%b PCD=%h PCPlus4D=%h", addr2, valid2, pcd2, pc4_2);
        check("wrap_valid", 32'(valid2), 32'h1);
        check("wrap_pcd", pcd2, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_2, 32'h0);
        check("wrap_instr", instr2, 32'hFFFC_0003);
        check("wrap_addr1", addr2, 32'h0);
        @(negedge clk);
        #1;
        $display("[TB] wrap1: addr=%h ValidD=%b PCD=%h PCPlus4D=%h", addr2, valid2, pcd2, pc4_2);
        check("wrap_pcd1", pcd2, 32'h0);
        check("wrap_addr2", addr2, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001: Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
- REQ-002: clk  in  1  sole clock, all state updates on rising edge.
- REQ-003: reset  in  1  synchronous, active-high reset.
- REQ-004: imem_addr  out  32  fetch address, equal to PCF.
- REQ-005: imem_req  out  1  fetch request, held with stable imem_addr until imem_ready.
- REQ-006: imem_ready  in  1  imem_rdata valid this cycle, completes the request.
- REQ-007: imem_rdata  in  32  returned instruction word.
- REQ-008: PCSrc  in  1  redirect (taken branch/jal) from execute.
- REQ-009: PCTarget  in  32  redirect address.
- REQ-010: StallD  in  1  decode cannot accept a new instruction.
- REQ-011: InstrD  out  32  IF/ID instruction; InstrD[6:0] drives the main decoder op.
- REQ-012: PCD  out  32  PC of InstrD.
- REQ-013: PCPlus4D  out  32  PCD+4.
- REQ-014: ValidD  out  1  InstrD is a real instruction, not a bubble.

Function
- REQ-015: States FETCH, BUFFERED, DROP; imem_req SHALL be 1 in FETCH and DROP, 0 in BUFFERED and while reset is high.
- REQ-016: FETCH, imem_ready, !PCSrc, !StallD: InstrD<=imem_rdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4; one instruction per cycle with zero-wait memory.
- REQ-017: FETCH, imem_ready, !PCSrc, StallD: word and PC captured in 1-entry skid buffer, PCF<=PCF+4, go BUFFERED; IF/ID registers hold.
- REQ-018: FETCH, !imem_ready, !PCSrc: ValidD<=0 and InstrD<=32'h0000_0013 if !StallD; IF/ID hold if StallD.
- REQ-019: BUFFERED, !StallD, !PCSrc: IF/ID<=skid contents, ValidD<=1, go FETCH; StallD high holds everything.
- REQ-020: PCSrc in any state SHALL flush: ValidD<=0, InstrD<=32'h0000_0013, skid cleared, regardless of StallD.
- REQ-021: PCSrc in FETCH with imem_ready, or in BUFFERED: PCF<=PCTarget, next state FETCH, returned word discarded.
- REQ-022: PCSrc in FETCH without imem_ready: redir_pc<=PCTarget, PCF unchanged, go DROP (outstanding request is never withdrawn).
- REQ-023: DROP: keep requesting PCF; on imem_ready discard data, PCF<=redir_pc, go FETCH; PCSrc in DROP overwrites redir_pc (latest wins).
- REQ-024: Priority reset > PCSrc > StallD > fetch progress.
- REQ-025: PC arithmetic modulo 2^32; PCF=32'hFFFF_FFFC increments to 32'h0000_0000 without error.
- REQ-026: No combinational path from imem_rdata, StallD or PCSrc to imem_addr; imem_addr depends only on registered state.

Reset
- REQ-027: Reset SHALL set PCF=RESET_PC, state FETCH, skid empty, redir_pc=0, ValidD=0, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0.
- REQ-028: Reset mid-operation SHALL abandon any outstanding request; an imem_ready arriving while reset is high is ignored.
- REQ-029: First request (imem_addr=RESET_PC) SHALL be issued in the first cycle after reset deasserts.

Configuration
- REQ-030: Macro IF_STAGE_PERF_CNT_EN defined: extra outputs fetch_cnt (32, instructions loaded into IF/ID with ValidD=1) and bubble_cnt (32, cycles IF/ID loaded with a bubble), both reset to 0, wrapping modulo 2^32.
- REQ-031: Macro undefined: ports and counters absent; all other behaviour identical.

Verification
- REQ-032: Reset, zero-wait memory (imem_ready=1), StallD=0 -> PCD 0,4,8,12 on consecutive cycles, ValidD=1 from cycle 2.
- REQ-033: StallD=1 for 3 cycles while imem_ready=1 at PCF=8 -> one word buffered, imem_req=0 for 2 cycles, InstrD at PC 8 presented after release, no word lost or duplicated.
- REQ-034: PCSrc=1, PCTarget=32'h100 with imem_ready=0 -> DROP, old address kept until ready, its data discarded, next imem_addr=32'h100, ValidD=0 throughout.
- REQ-035: PCSrc and StallD both high in BUFFERED -> ValidD=0, InstrD=32'h0000_0013, next imem_addr=PCTarget.
- REQ-036: RESET_PC=32'hFFFF_FFFC, zero-wait -> second imem_addr=32'h0000_0000, PCPlus4D=32'h0000_0000 for first instruction.
- REQ-037: With IF_STAGE_PERF_CNT_EN, 10 cycles zero-wait then 2 cycles imem_ready=0 -> fetch_cnt=10, bubble_cnt=2 (excluding reset cycles).
